// File: rtl/led_chaser_if.sv
// Control and LED drive bundle for led_chaser.
// The master side drives en/dir/step_in. The slave side (the chaser) drives led/phase/cycle_done.
interface led_chaser_if #(
  parameter int unsigned N = 8
) ();
  logic         en;
  logic         dir;
  logic         step_in;
  logic [N-1:0] led;
  logic [1:0]   phase;
  logic         cycle_done;

  modport master (output en, dir, step_in, input led, phase, cycle_done);
  modport slave  (input en, dir, step_in, output led, phase, cycle_done);
endinterface

// File: rtl/led_chaser.sv
// LED chaser: fills the LED bar one lamp per slow step, drains it in the same order,
// then stays dark for HOLD_STEPS steps before it repeats.
module led_chaser #(
  parameter int unsigned N          = 8,
  parameter int unsigned HOLD_STEPS = 2
) (
  input logic          clk,
  input logic          reset,
  led_chaser_if.slave  bus
);

  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] HOLD_LAST = (HOLD_STEPS == 0) ? CW'(0) : CW'(HOLD_STEPS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  led_q, led_d;
  logic          dir_q, dir_d;
  logic [CW-1:0] hold_cnt_q, hold_cnt_d;
  logic          cycle_done_q, cycle_done_d;
  logic          s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic          step_q, step_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      led_q        <= '0;
      dir_q        <= 1'b0;
      hold_cnt_q   <= '0;
      cycle_done_q <= 1'b0;
      s1_q         <= 1'b0;
      s2_q         <= 1'b0;
      s3_q         <= 1'b0;
      step_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      led_q        <= led_d;
      dir_q        <= dir_d;
      hold_cnt_q   <= hold_cnt_d;
      cycle_done_q <= cycle_done_d;
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      s3_q         <= s3_d;
      step_q       <= step_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    led_d        = led_q;
    dir_d        = dir_q;
    hold_cnt_d   = hold_cnt_q;
    cycle_done_d = 1'b0;
    // The edge-detected step is registered once more, so the FSM acts three edges after step_in is first sampled.
    s1_d         = bus.step_in;
    s2_d         = s1_q;
    s3_d         = s2_q;
    step_d       = s2_q & ~s3_q;

    if (!bus.en) begin
      state_d    = IDLE;
      led_d      = '0;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = FILL;
          dir_d   = bus.dir;
          led_d   = '0;
        end
        FILL: begin
          if (step_q) begin
            led_d = dir_q ? {led_q[N-2:0], 1'b1} : {1'b1, led_q[N-1:1]};
            if (&led_d) state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (step_q) begin
            led_d = dir_q ? {led_q[N-2:0], 1'b0} : {1'b0, led_q[N-1:1]};
            if (led_d == '0) begin
              cycle_done_d = 1'b1;
              hold_cnt_d   = '0;
              if (HOLD_STEPS == 0) begin
                state_d = FILL;
                dir_d   = bus.dir;
              end else begin
                state_d = HOLD;
              end
            end
          end
        end
        HOLD: begin
          led_d = '0;
          if (step_q) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d    = FILL;
              dir_d      = bus.dir;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + CW'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.led        = led_q;
  assign bus.phase      = state_q;
  assign bus.cycle_done = cycle_done_q;

endmodule

// File: tb/tb_led_chaser.sv
// Scoreboard bench for led_chaser. Two instances (HOLD_STEPS=2 and HOLD_STEPS=0) get the same stimulus.
// An abstract lamp-count model predicts each instance's output.
module tb_led_chaser;

  localparam int N = 8;
  localparam int P_IDLE = 0, P_FILL = 1, P_DRAIN = 2, P_HOLD = 3;

  typedef struct {
    int         due;
    logic [7:0] led;
    logic [1:0] ph;
    logic       cd;
  } exp_t;

  logic clk = 1'b0;
  logic reset_r, en_r, dir_r, step_r;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 0;

  exp_t q0[$];
  exp_t q1[$];
  int   ph_m[2], cnt_m[2], hc_m[2], dl_m[2];
  logic [7:0] cur_led[2];
  logic [1:0] cur_ph[2];

  led_chaser_if #(.N(N)) bus0 ();
  led_chaser_if #(.N(N)) bus1 ();

  assign bus0.en = en_r;  assign bus0.dir = dir_r;  assign bus0.step_in = step_r;
  assign bus1.en = en_r;  assign bus1.dir = dir_r;  assign bus1.step_in = step_r;

  led_chaser #(.N(N), .HOLD_STEPS(2)) u_dut_h2 (.clk(clk), .reset(reset_r), .bus(bus0));
  led_chaser #(.N(N), .HOLD_STEPS(0)) u_dut_h0 (.clk(clk), .reset(reset_r), .bus(bus1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int hold_steps(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  // Top m lamps lit (dir 0) or bottom m lamps lit (dir 1).
  function automatic logic [7:0] fill_pat(input int m, input int dl);
    int v;
    v = (1 << m) - 1;
    if (dl == 0) v = v << (N - m);
    return 8'(v);
  endfunction

  // After d lamps went dark, the remaining N-d lamps sit at the far end.
  function automatic logic [7:0] drain_pat(input int d, input int dl);
    int v;
    v = (1 << (N - d)) - 1;
    if (dl != 0) v = v << d;
    return 8'(v);
  endfunction

  task automatic push(input int d, input int due, input logic [7:0] led, input int ph, input logic cd);
    exp_t e;
    e.due = due; e.led = led; e.ph = 2'(ph); e.cd = cd;
    if (d == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic flush(input int d, input int after);
    if (d == 0) begin
      while (q0.size() > 0 && q0[q0.size()-1].due > after) void'(q0.pop_back());
    end else begin
      while (q1.size() > 0 && q1[q1.size()-1].due > after) void'(q1.pop_back());
    end
  endtask

  task automatic model_step(input int d, input int due);
    case (ph_m[d])
      P_FILL: begin
        cnt_m[d]++;
        push(d, due, fill_pat(cnt_m[d], dl_m[d]), (cnt_m[d] == N) ? P_DRAIN : P_FILL, 1'b0);
        if (cnt_m[d] == N) begin ph_m[d] = P_DRAIN; cnt_m[d] = 0; end
      end
      P_DRAIN: begin
        cnt_m[d]++;
        if (cnt_m[d] == N) begin
          cnt_m[d] = 0;
          hc_m[d]  = 0;
          if (hold_steps(d) == 0) begin ph_m[d] = P_FILL; dl_m[d] = int'(dir_r); end
          else ph_m[d] = P_HOLD;
          push(d, due, 8'h00, ph_m[d], 1'b1);
        end else begin
          push(d, due, drain_pat(cnt_m[d], dl_m[d]), P_DRAIN, 1'b0);
        end
      end
      P_HOLD: begin
        hc_m[d]++;
        if (hc_m[d] == hold_steps(d)) begin
          ph_m[d] = P_FILL; cnt_m[d] = 0; hc_m[d] = 0; dl_m[d] = int'(dir_r);
        end
        push(d, due, 8'h00, ph_m[d], 1'b0);
      end
      default: ;
    endcase
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_step();
    step_r = 1'b1;
    for (int d = 0; d < 2; d++) model_step(d, cyc + 4);
  endtask

  task automatic step_pulse(input int hi, input int lo);
    issue_step();
    repeat (hi) next();
    step_r = 1'b0;
    repeat (lo) next();
  endtask

  task automatic en_rise();
    en_r = 1'b1;
    for (int d = 0; d < 2; d++) begin
      push(d, cyc + 1, 8'h00, P_FILL, 1'b0);
      ph_m[d] = P_FILL; cnt_m[d] = 0; dl_m[d] = int'(dir_r);
    end
  endtask

  task automatic en_drop();
    en_r = 1'b0;
    for (int d = 0; d < 2; d++) begin
      flush(d, cyc);
      push(d, cyc + 1, 8'h00, P_IDLE, 1'b0);
      ph_m[d] = P_IDLE; hc_m[d] = 0;
    end
  endtask

  task automatic do_reset();
    reset_r = 1'b1;
    for (int d = 0; d < 2; d++) begin
      flush(d, cyc);
      push(d, cyc + 1, 8'h00, P_IDLE, 1'b0);
      ph_m[d] = P_IDLE; hc_m[d] = 0;
      if (en_r) begin
        push(d, cyc + 2, 8'h00, P_FILL, 1'b0);
        ph_m[d] = P_FILL; cnt_m[d] = 0; dl_m[d] = int'(dir_r);
      end
    end
    next();
    reset_r = 1'b0;
  endtask

  task automatic mon(input int d, input logic [7:0] led, input logic [1:0] ph, input logic cd);
    exp_t e;
    bit   got;
    logic exp_cd;
    got = 0;
    if (d == 0 && q0.size() > 0 && q0[0].due <= cyc) begin e = q0.pop_front(); got = 1; end
    if (d == 1 && q1.size() > 0 && q1[0].due <= cyc) begin e = q1.pop_front(); got = 1; end
    exp_cd = 1'b0;
    if (got) begin
      checks++;
      if (e.due != cyc) begin
        errors++;
        $display("FAIL dut%0d timing: expected change at cycle %0d, checked at %0d", d, e.due, cyc);
      end
      cur_led[d] = e.led; cur_ph[d] = e.ph; exp_cd = e.cd;
    end
    checks++;
    if (led !== cur_led[d]) begin
      errors++;
      $display("FAIL dut%0d led cyc=%0d got=%h exp=%h", d, cyc, led, cur_led[d]);
    end
    checks++;
    if (ph !== cur_ph[d]) begin
      errors++;
      $display("FAIL dut%0d phase cyc=%0d got=%0d exp=%0d", d, cyc, ph, cur_ph[d]);
    end
    checks++;
    if (cd !== exp_cd) begin
      errors++;
      $display("FAIL dut%0d cycle_done cyc=%0d got=%b exp=%b", d, cyc, cd, exp_cd);
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      mon(0, bus0.led, bus0.phase, bus0.cycle_done);
      mon(1, bus1.led, bus1.phase, bus1.cycle_done);
    end
  end

  initial begin
    reset_r = 1'b1; en_r = 1'b0; dir_r = 1'b0; step_r = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ph_m[d] = P_IDLE; cnt_m[d] = 0; hc_m[d] = 0; dl_m[d] = 0;
      cur_led[d] = 8'h00; cur_ph[d] = 2'd0;
    end
    next();
    armed = 1;
    next();
    reset_r = 1'b0;
    repeat (3) next();

    // Left-to-right chase, step_in toggling every 8 clocks, through hold and into the next fill.
    dir_r = 1'b0; en_rise(); next();
    repeat (20) step_pulse(8, 8);
    en_drop(); next(); next();

    // Right-to-left chase; dir flips mid-fill and takes effect only at the next fill.
    dir_r = 1'b1; en_rise(); next();
    repeat (3) step_pulse(8, 8);
    dir_r = 1'b0;
    repeat (20) step_pulse(8, 8);

    // A long high period yields exactly one step.
    step_pulse(50, 6);

    // Reset at 0xE0 with en held high.
    en_drop(); next(); next();
    dir_r = 1'b0; en_rise(); next();
    repeat (3) step_pulse(3, 3);
    do_reset();
    repeat (2) next();

    // en dropped on the same edge as a drain step at 0x3F.
    repeat (10) step_pulse(4, 4);
    issue_step(); repeat (3) next();
    en_drop(); repeat (3) next();
    step_r = 1'b0; repeat (4) next();

    // A step landing on the IDLE->FILL edge is discarded.
    issue_step(); repeat (3) next();
    en_rise(); repeat (3) next();
    step_r = 1'b0; repeat (4) next();
    step_pulse(4, 4);

    // step_in already high while reset releases.
    step_r = 1'b1;
    do_reset();
    for (int d = 0; d < 2; d++) model_step(d, cyc + 4);
    repeat (4) next();
    step_r = 1'b0; repeat (4) next();

    // Randomized steps, directions and enable drops.
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        en_drop(); next(); next();
        en_rise(); next();
      end
      dir_r = 1'($urandom_range(0, 1));
      step_pulse(int'($urandom_range(2, 6)), int'($urandom_range(2, 6)));
    end

    repeat (6) next();
    checks++;
    if (q0.size() != 0) begin
      errors++;
      $display("FAIL dut0 leftover: %0d expected events never seen, required 0", q0.size());
    end
    checks++;
    if (q1.size() != 0) begin
      errors++;
      $display("FAIL dut1 leftover: %0d expected events never seen, required 0", q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_chaser.md
LED_CHASER -- requirements
Module: led_chaser

Interface
REQ-001 Parameter N, default 8: number of LEDs (width of led); legal range 2..32.
REQ-002 Parameter HOLD_STEPS, default 2: number of dark steps between cycles; legal range 0..255.
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on rising clk.
REQ-005 en  input  1  run enable; level; low forces IDLE.
REQ-006 dir  input  1  0 = light/extinguish left to right (led[N-1] first); 1 = right to left (led[0] first).
REQ-007 step_in  input  1  slow step source from the divider bit; asynchronous to use; any duty cycle; each high period lasts at least 2 clk cycles.
REQ-008 led  output  N  LED drive; 1 = lit.
REQ-009 phase  output  2  current state: 0 IDLE, 1 FILL, 2 DRAIN, 3 HOLD.
REQ-010 cycle_done  output  1  one-clk pulse when DRAIN completes.

Function
REQ-011 step_in SHALL pass through a 2-flop synchroniser (s1, s2) plus a history flop s3; step = s2 & ~s3.
REQ-012 Step latency is fixed: if step_in is first sampled high at edge k, step is high between edges k+2 and k+3, and led changes at edge k+3.
REQ-013 step SHALL be high for exactly one clk per rising edge of step_in; a falling edge produces no step.
REQ-014 IDLE: led = 0, no step counted; en high moves the FSM to FILL at the next edge and latches dir into dir_q; led stays 0 on entry.
REQ-015 FILL, per step: dir_q=0 -> led <= {1, led[N-1:1]}; dir_q=1 -> led <= {led[N-2:0], 1}.
REQ-016 FILL: the step that makes led all ones SHALL also move the FSM to DRAIN; the FSM takes N steps from led=0.
REQ-017 DRAIN, per step: dir_q=0 -> led <= {0, led[N-1:1]}; dir_q=1 -> led <= {led[N-2:0], 0}. Lit LEDs go dark in the same order they lit.
REQ-018 DRAIN: the step that makes led zero SHALL pulse cycle_done for that one cycle and move the FSM to HOLD, clearing hold_cnt. If HOLD_STEPS=0, that step goes straight to FILL and re-latches dir.
REQ-019 HOLD: led = 0; each step increments hold_cnt; the step where hold_cnt = HOLD_STEPS-1 SHALL move the FSM to FILL and latch dir into dir_q.
REQ-020 dir changes outside FILL entry SHALL be ignored until the next FILL entry.
REQ-021 en low in any non-IDLE state SHALL move the FSM to IDLE at the next edge with led=0, hold_cnt=0, and no cycle_done. This has priority over a simultaneous step.
REQ-022 A step in IDLE, or a step arriving the same cycle as the IDLE->FILL transition, SHALL be discarded.
REQ-023 phase SHALL always reflect the registered state; led and cycle_done are registered outputs with no combinational path from inputs.
REQ-024 hold_cnt width is 8 bits; it SHALL never wrap within HOLD.

Reset
REQ-025 While reset is high at a clk edge, the block SHALL set: state IDLE, led=0, phase=0, cycle_done=0, s1=s2=s3=0, hold_cnt=0, dir_q=0.
REQ-026 reset SHALL take priority over en and step; reset mid-FILL/DRAIN aborts immediately with no cycle_done.
REQ-027 After reset releases, a step_in that is already high SHALL produce one step, 3 edges later (REQ-012); the FSM handles it per REQ-022.

Verification
REQ-028 N=8, HOLD_STEPS=2, dir=0, en=1, step_in toggling every 8 clk -> led goes 0x80, 0xC0, ..., 0xFF, then 0x7F, 0x3F, ..., 0x00 with cycle_done at 0x00, then 2 dark steps, then 0x80 again.
REQ-029 dir=1, same stimulus -> led goes 0x01, 0x03, ..., 0xFF, 0xFE, ..., 0x00; dir toggled mid-FILL -> sequence unchanged until the next FILL.
REQ-030 step_in rises at a known edge k -> led changes exactly at edge k+3; step_in held high for 50 clk -> exactly one step.
REQ-031 en dropped in the same cycle as a step during DRAIN at led=0x3F -> next edge: phase=0, led=0x00, cycle_done=0.
REQ-032 reset asserted for 1 clk at led=0xE0 -> next edge: all outputs 0; with en=1 held, phase=1 one edge after reset release.
REQ-033 HOLD_STEPS=0 -> the DRAIN step reaching 0x00 pulses cycle_done and the next step gives led=0x80.
